fetch_unit: RTL and testbench

// - Front-end requester for the instruction memory: owns the PC and issues word-aligned fetch requests.
// - Collects in-order responses (latency >= 1 cycle) into an instruction buffer.
// - Presents {instr, pc} to decode over a valid/ready handshake.
// - Handles control-flow redirects: flushes buffered instructions and discards stale in-flight responses.

---
 rtl/tartaruga_pkg.sv | 21 ++
 rtl/fetch_ibuf.sv | 59 +++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// Shared types for the tartaruga front end.
// Bus word, fetch FSM states and instruction-buffer entry.
package tartaruga_pkg;

    typedef logic [31:0] bus32_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        bus32_t instr;
        bus32_t pc;
    } ibuf_entry_t;

    function automatic bus32_t word_align(bus32_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ibuf.sv
// Instruction buffer: small synchronous FIFO of {instr, pc} entries.
// flush empties the buffer and wins over push and pop.
module fetch_ibuf
    import tartaruga_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        push,
    input  ibuf_entry_t wdata,
    input  logic        pop,
    input  logic        flush,
    output ibuf_entry_t rdata,
    output logic [CW-1:0] count,
    output logic        empty,
    output logic        full
);

    ibuf_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop = pop & ~empty;
    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign rdata  = mem_q[rd_q];

    // Storage is reset too so the head output reads zero out of reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues word fetches, buffers in-order
// responses and drops stale ones after a control-flow redirect.
module fetch_unit
    import tartaruga_pkg::*;
#(
    parameter bus32_t RESET_PC        = 32'h0000_0000,
    parameter int     IBUF_DEPTH      = 4,
    parameter int     MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        req_valid_o,
    output logic [31:0] req_addr_o,
    input  logic        req_ready_i,
    input  logic        resp_valid_i,
    input  logic [31:0] resp_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int CW = $clog2(IBUF_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_e  state_q;
    bus32_t        pc_q;
    bus32_t        resp_pc_q;
    logic [OW-1:0] outstanding_q;
    logic [OW-1:0] drop_q;
    logic [OW-1:0] out_next;

    logic          req_fire;
    logic          resp_fire;
    logic          push;
    logic          pop;
    logic          room_ok;
    logic          slot_ok;
    ibuf_entry_t   head;
    ibuf_entry_t   wentry;
    logic [CW-1:0] buf_count;
    logic          ibuf_empty;
    logic          ibuf_full;

    // Reserving a slot per in-flight request means responses never stall.
    assign room_ok = (32'(outstanding_q) + 32'(buf_count)) < 32'(IBUF_DEPTH);
    assign slot_ok = 32'(outstanding_q) < 32'(MAX_OUTSTANDING);

    assign req_valid_o = rstn_i & (state_q == RUN) & room_ok & slot_ok;
    assign req_addr_o  = pc_q;

    assign req_fire  = req_valid_o & req_ready_i;
    assign resp_fire = resp_valid_i;
    assign out_next  = outstanding_q + OW'(req_fire) - OW'(resp_fire);

    assign push = resp_fire & (drop_q == '0) & ~redirect_i
                & (~ibuf_full | pop);
    assign pop  = instr_valid_o & instr_ready_i;

    assign wentry = '{instr: resp_instr_i, pc: resp_pc_q};

    assign instr_valid_o = ~ibuf_empty;
    assign instr_o       = head.instr;
    assign instr_pc_o    = head.pc;

    fetch_ibuf #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (push),
        .wdata  (wentry),
        .pop    (pop),
        .flush  (redirect_i),
        .rdata  (head),
        .count  (buf_count),
        .empty  (ibuf_empty),
        .full   (ibuf_full)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            outstanding_q <= out_next;
            // Everything still in flight after this edge is stale.
            if (redirect_i) begin
                pc_q      <= word_align(redirect_pc_i);
                resp_pc_q <= word_align(redirect_pc_i);
                drop_q    <= out_next;
                state_q   <= (out_next != '0) ? FLUSH : RUN;
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (push) begin
                    resp_pc_q <= resp_pc_q + 32'd4;
                end
                if (resp_fire && (drop_q != '0)) begin
                    drop_q <= drop_q - 1'b1;
                end
                if ((state_q == FLUSH) && resp_fire && (drop_q == OW'(1))) begin
                    state_q <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency memory model
// and a scoreboard of instructions accepted by decode.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        req_ready_i;
    logic        resp_valid_i;
    logic [31:0] resp_instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    int checks = 0;
    int errors = 0;
    int lat    = 1;
    int cyc    = 0;

    logic [31:0] mem [256];
    logic [31:0] q_addr [$];
    int          q_due  [$];
    logic [31:0] d_pc    [$];
    logic [31:0] d_instr [$];

    fetch_unit dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .req_valid_o   (req_valid_o),
        .req_addr_o    (req_addr_o),
        .req_ready_i   (req_ready_i),
        .resp_valid_i  (resp_valid_i),
        .resp_instr_i  (resp_instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h1357_0000 + 32'(i);
        end
    end

    // In-order memory: a request fired in cycle c answers in cycle c+lat.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            q_addr.delete();
            q_due.delete();
            cyc = 0;
            resp_valid_i <= 1'b0;
            resp_instr_i <= '0;
        end else begin
            cyc = cyc + 1;
            if (resp_valid_i) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (req_valid_o && req_ready_i) begin
                q_addr.push_back(req_addr_o);
                q_due.push_back(cyc - 1 + lat);
            end
            if (q_due.size() > 0 && q_due[0] <= cyc) begin
                resp_valid_i <= 1'b1;
                resp_instr_i <= mem[q_addr[0][9:2]];
            end else begin
                resp_valid_i <= 1'b0;
                resp_instr_i <= '0;
            end
        end
    end

    always @(posedge clk_i) begin
        if (rstn_i && instr_valid_o && instr_ready_i && !redirect_i) begin
            d_pc.push_back(instr_pc_o);
            d_instr.push_back(instr_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_deliv(input int n, input int budget);
        int k = 0;
        while (d_pc.size() < n && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        checks++;
        assert (d_pc.size() >= n) else begin
            errors++;
            $error("FAIL deliv_timeout: got %0d entries expected %0d",
                   d_pc.size(), n);
        end
    endtask

    task automatic chk_deliv(input string tag, input int idx,
                             input logic [31:0] pc);
        logic [31:0] exp_instr;
        exp_instr = mem[pc[9:2]];
        chk({tag, "_pc"}, d_pc[idx], pc);
        chk({tag, "_instr"}, d_instr[idx], exp_instr);
    endtask

    task automatic do_reset(input int l, input logic rdy);
        @(negedge clk_i);
        rstn_i        = 1'b0;
        lat           = l;
        instr_ready_i = rdy;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        req_ready_i   = 1'b1;
        repeat (2) @(negedge clk_i);
        d_pc.delete();
        d_instr.delete();
        rstn_i = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn_i        = 1'b0;
        lat           = 1;
        instr_ready_i = 1'b1;
        req_ready_i   = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        repeat (2) @(negedge clk_i);

        // 1: reset values, then streaming with a 1-cycle memory
        chk("rst_req_valid", 32'(req_valid_o), 32'd0);
        chk("rst_req_addr", req_addr_o, 32'h0);
        chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_instr_pc", instr_pc_o, 32'h0);
        rstn_i = 1'b1;
        #1;
        chk("t1_req_valid", 32'(req_valid_o), 32'd1);
        chk("t1_addr0", req_addr_o, 32'h0);
        @(negedge clk_i);
        chk("t1_addr1", req_addr_o, 32'h4);
        chk("t1_ivalid_c1", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i);
        chk("t1_addr2", req_addr_o, 32'h8);
        chk("t1_ivalid_c2", 32'(instr_valid_o), 32'd1);
        chk("t1_head_pc", instr_pc_o, 32'h0);
        chk("t1_head_instr", instr_o, mem[0]);

        // 2: decode stalled fills the buffer exactly
        do_reset(1, 1'b0);
        repeat (8) @(negedge clk_i);
        chk("t2_req_stopped", 32'(req_valid_o), 32'd0);
        chk("t2_next_addr", req_addr_o, 32'h10);
        chk("t2_ivalid", 32'(instr_valid_o), 32'd1);
        chk("t2_head_pc", instr_pc_o, 32'h0);
        instr_ready_i = 1'b1;
        wait_deliv(5, 20);
        chk_deliv("t2_d0", 0, 32'h0);
        chk_deliv("t2_d1", 1, 32'h4);
        chk_deliv("t2_d2", 2, 32'h8);
        chk_deliv("t2_d3", 3, 32'hC);
        chk_deliv("t2_d4", 4, 32'h10);

        // 3: redirect with two requests in flight, 3-cycle memory
        do_reset(3, 1'b1);
        repeat (2) @(negedge clk_i);
        chk("t3_inflight_stall", 32'(req_valid_o), 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        @(negedge clk_i);
        redirect_i = 1'b0;
        chk("t3_flush_valid", 32'(req_valid_o), 32'd0);
        chk("t3_target", req_addr_o, 32'h100);
        @(negedge clk_i);
        chk("t3_flush_valid2", 32'(req_valid_o), 32'd0);
        @(negedge clk_i);
        chk("t3_run_valid", 32'(req_valid_o), 32'd1);
        chk("t3_run_addr", req_addr_o, 32'h100);
        wait_deliv(2, 20);
        chk_deliv("t3_d0", 0, 32'h100);
        chk_deliv("t3_d1", 1, 32'h104);

        // 4: redirect together with a request fire and a response fire
        do_reset(1, 1'b1);
        repeat (4) @(negedge clk_i);
        chk("t4_pre_req", 32'(req_valid_o), 32'd1);
        chk("t4_pre_ivalid", 32'(instr_valid_o), 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h400;
        d_pc.delete();
        d_instr.delete();
        @(negedge clk_i);
        redirect_i = 1'b0;
        chk("t4_flush_valid", 32'(req_valid_o), 32'd0);
        chk("t4_target", req_addr_o, 32'h400);
        chk("t4_cleared", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i);
        chk("t4_run_valid", 32'(req_valid_o), 32'd1);
        chk("t4_run_addr", req_addr_o, 32'h400);
        wait_deliv(2, 20);
        chk_deliv("t4_d0", 0, 32'h400);
        chk_deliv("t4_d1", 1, 32'h404);

        // 5: second redirect while still flushing, misaligned target
        do_reset(3, 1'b1);
        repeat (2) @(negedge clk_i);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        @(negedge clk_i);
        chk("t5_first_target", req_addr_o, 32'h200);
        chk("t5_flush1", 32'(req_valid_o), 32'd0);
        redirect_pc_i = 32'h303;
        @(negedge clk_i);
        redirect_i = 1'b0;
        chk("t5_second_target", req_addr_o, 32'h300);
        chk("t5_flush2", 32'(req_valid_o), 32'd0);
        @(negedge clk_i);
        chk("t5_run_valid", 32'(req_valid_o), 32'd1);
        chk("t5_run_addr", req_addr_o, 32'h300);
        wait_deliv(2, 20);
        chk_deliv("t5_d0", 0, 32'h300);
        chk_deliv("t5_d1", 1, 32'h304);

        // 6: asynchronous reset with a full buffer
        do_reset(2, 1'b0);
        repeat (10) @(negedge clk_i);
        chk("t6_full_ivalid", 32'(instr_valid_o), 32'd1);
        chk("t6_full_addr", req_addr_o, 32'h10);
        rstn_i = 1'b0;
        #1;
        chk("t6_rst_req_valid", 32'(req_valid_o), 32'd0);
        chk("t6_rst_addr", req_addr_o, 32'h0);
        chk("t6_rst_ivalid", 32'(instr_valid_o), 32'd0);
        chk("t6_rst_instr", instr_o, 32'h0);
        chk("t6_rst_pc", instr_pc_o, 32'h0);
        @(negedge clk_i);
        d_pc.delete();
        d_instr.delete();
        instr_ready_i = 1'b1;
        rstn_i        = 1'b1;
        #1;
        chk("t6_restart_valid", 32'(req_valid_o), 32'd1);
        chk("t6_restart_addr", req_addr_o, 32'h0);
        wait_deliv(1, 20);
        chk_deliv("t6_d0", 0, 32'h0);

        // 7: PC wraps past the top of the address space
        do_reset(1, 1'b1);
        repeat (4) @(negedge clk_i);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        d_pc.delete();
        d_instr.delete();
        @(negedge clk_i);
        redirect_i = 1'b0;
        wait_deliv(3, 20);
        chk_deliv("t7_d0", 0, 32'hFFFF_FFF8);
        chk_deliv("t7_d1", 1, 32'hFFFF_FFFC);
        chk_deliv("t7_d2", 2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
